i2c_slave: RTL and testbench

//  I2C target (responder) for the 400 kHz bus driven by i2c_master; sits on scl/sda and fronts a byte-wide

---
 rtl/i2c_slave_pkg.sv | 23 ++
 rtl/i2c_slave_bus_sync.sv | 43 ++++
 rtl/i2c_slave.sv | 191 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, ACK/NACK levels
// and the bit-counter width.
package i2c_slave_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      SUB,
      SUB_ACK,
      WR,
      WR_ACK,
      RD,
      RD_ACK,
      IGNORE
   } state_t;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_slave_bus_sync.sv
// Brings scl/sda into the i_clk domain and derives one-cycle SCL edge and
// START/STOP condition pulses.
module i2c_slave_bus_sync (
   input  logic i_clk,
   input  logic reset_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic scl_meta, scl_sync, scl_hist;
   logic sda_meta, sda_sync, sda_hist;

   // Flops reset to 1 so an idle (pulled-up) bus produces no edges out of reset.
   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_meta <= 1'b1;
         scl_sync <= 1'b1;
         scl_hist <= 1'b1;
         sda_meta <= 1'b1;
         sda_sync <= 1'b1;
         sda_hist <= 1'b1;
      end else begin
         scl_meta <= scl_i;
         scl_sync <= scl_meta;
         scl_hist <= scl_sync;
         sda_meta <= sda_i;
         sda_sync <= sda_meta;
         sda_hist <= sda_sync;
      end
   end

   assign sda      = sda_sync;
   assign scl_rise = scl_sync & ~scl_hist;
   assign scl_fall = ~scl_sync & scl_hist;
   assign start    = scl_sync & scl_hist & sda_hist & ~sda_sync;
   assign stop     = scl_sync & scl_hist & ~sda_hist & sda_sync;

endmodule

// File: rtl/i2c_slave.sv
// I2C target fronting a byte-wide register file: address match, sub-address
// pointer, then auto-incrementing sequential writes or reads.
module i2c_slave
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h4B,
   parameter int         HOLD_CYCLES = 4
) (
   input  logic       i_clk,
   input  logic       reset_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   logic sda, scl_rise, scl_fall, start, stop;

   i2c_slave_bus_sync u_sync (
      .i_clk    (i_clk),
      .reset_n  (reset_n),
      .scl_i    (scl_i),
      .sda_i    (sda_i),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   state_t               state;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [7:0]           shift;
   logic                 rw_bit;
   logic                 ack_rose;
   logic                 ack_bit;
   logic                 pend_oe;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [7:0]           shifted;

   assign shifted = {shift[6:0], sda};

   // Every ACK state spans two falls: the first starts the ACK bit, the rise in
   // between marks it as sampled, and the second fall moves on. SDA changes are
   // staged in pend_oe and applied HOLD_CYCLES after the fall; in RD the bit
   // comes straight from the shift register, which is loaded by then.
   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         bit_cnt   <= '1;
         shift     <= '0;
         rw_bit    <= 1'b0;
         ack_rose  <= 1'b0;
         ack_bit   <= NACK;
         pend_oe   <= 1'b0;
         hold_cnt  <= '0;
         sda_oe    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         reg_we <= 1'b0;
         reg_re <= 1'b0;
         if (reg_re)
            shift <= reg_rdata;
         if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_ONE;
            if (hold_cnt == HOLD_ONE)
               sda_oe <= (state == RD) ? ~shift[7] : pend_oe;
         end

         if (start) begin
            state    <= ADDR;
            bit_cnt  <= '1;
            sda_oe   <= 1'b0;
            pend_oe  <= 1'b0;
            hold_cnt <= '0;
            ack_rose <= 1'b0;
         end else if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            sda_oe   <= 1'b0;
            pend_oe  <= 1'b0;
            hold_cnt <= '0;
            ack_rose <= 1'b0;
         end else if (scl_rise) begin
            case (state)
               ADDR, SUB, WR: begin
                  shift <= shifted;
                  if (bit_cnt == '0) begin
                     bit_cnt <= '1;
                     case (state)
                        ADDR: begin
                           // Address 0 is the general call, which is not answered.
                           if (shifted[7:1] == SLAVE_ADDR && shifted[7:1] != 7'd0) begin
                              state  <= ADDR_ACK;
                              busy   <= 1'b1;
                              rw_bit <= shifted[0];
                           end else begin
                              state <= IGNORE;
                              busy  <= 1'b0;
                           end
                        end
                        SUB: begin
                           reg_addr <= shifted;
                           state    <= SUB_ACK;
                        end
                        default: begin
                           reg_wdata <= shifted;
                           reg_we    <= 1'b1;
                           state     <= WR_ACK;
                        end
                     endcase
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
               RD: begin
                  if (bit_cnt == '0) begin
                     bit_cnt <= '1;
                     state   <= RD_ACK;
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
               ADDR_ACK, SUB_ACK, WR_ACK: ack_rose <= 1'b1;
               RD_ACK: begin
                  ack_rose <= 1'b1;
                  ack_bit  <= sda;
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            hold_cnt <= HOLD_LOAD;
            case (state)
               ADDR_ACK, SUB_ACK, WR_ACK: begin
                  if (!ack_rose) begin
                     pend_oe <= 1'b1;
                  end else begin
                     ack_rose <= 1'b0;
                     pend_oe  <= 1'b0;
                     case (state)
                        ADDR_ACK: begin
                           if (rw_bit) begin
                              state  <= RD;
                              reg_re <= 1'b1;
                           end else begin
                              state <= SUB;
                           end
                        end
                        SUB_ACK: state <= WR;
                        default: begin
                           state    <= WR;
                           reg_addr <= reg_addr + 8'd1;
                        end
                     endcase
                  end
               end
               RD: shift <= {shift[6:0], 1'b0};
               RD_ACK: begin
                  pend_oe <= 1'b0;
                  if (ack_rose) begin
                     ack_rose <= 1'b0;
                     reg_addr <= reg_addr + 8'd1;
                     if (ack_bit == ACK) begin
                        state   <= RD;
                        reg_re  <= 1'b1;
                        bit_cnt <= '1;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               default: pend_oe <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bit-banged bus master drives directed
// transfers while a monitor scores register-file strobes against expectations.
module tb_i2c_slave;

   logic       clk = 1'b0;
   logic       resetN;
   logic       scl;
   logic       sdaLow;
   logic       sdaOe;
   logic [7:0] regAddr;
   logic [7:0] regWdata;
   logic       regWe;
   logic       regRe;
   logic [7:0] regRdata;
   logic       busy;
   wire        sdaLine = ~(sdaLow | sdaOe);

   logic [7:0] regFile [256];
   assign regRdata = regFile[regAddr];

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wrEvent_t;

   wrEvent_t   expWr[$];
   logic [7:0] expRe[$];
   wrEvent_t   monWr;
   logic [7:0] monRe;

   int errors   = 0;
   int checks   = 0;
   int holdViol = 0;
   bit sawOe    = 1'b0;
   bit sawBusy  = 1'b0;
   logic oePrev  = 1'b0;
   logic sclPrev = 1'b1;

   always #5 clk = ~clk;

   i2c_slave dut (
      .i_clk     (clk),
      .reset_n   (resetN),
      .scl_i     (scl),
      .sda_i     (sdaLine),
      .sda_oe    (sdaOe),
      .reg_addr  (regAddr),
      .reg_wdata (regWdata),
      .reg_we    (regWe),
      .reg_re    (regRe),
      .reg_rdata (regRdata),
      .busy      (busy)
   );

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Set the bus levels driven by the master, then hold them for a number of clocks.
   task automatic applyStimulus(input logic sclV, input logic lowV, input int cycles);
      scl    = sclV;
      sdaLow = lowV;
      waitClk(cycles);
   endtask

   // Every bus task starts with SCL high at the end of a high phase and ends the same way.
   task automatic busStart();
      applyStimulus(1'b1, 1'b0, 10);
      applyStimulus(1'b1, 1'b1, 10);
   endtask

   task automatic busRepStart();
      applyStimulus(1'b0, sdaLow, 10);
      applyStimulus(1'b0, 1'b0, 10);
      applyStimulus(1'b1, 1'b0, 10);
      applyStimulus(1'b1, 1'b1, 10);
   endtask

   task automatic busStop();
      applyStimulus(1'b0, sdaLow, 10);
      applyStimulus(1'b0, 1'b1, 10);
      applyStimulus(1'b1, 1'b1, 10);
      applyStimulus(1'b1, 1'b0, 20);
   endtask

   task automatic writeBit(input logic b);
      applyStimulus(1'b0, sdaLow, 10);
      applyStimulus(1'b0, ~b, 10);
      applyStimulus(1'b1, ~b, 20);
   endtask

   task automatic readBit(output logic b);
      applyStimulus(1'b0, sdaLow, 10);
      applyStimulus(1'b0, 1'b0, 10);
      applyStimulus(1'b1, 1'b0, 10);
      b = sdaLine;
      applyStimulus(1'b1, 1'b0, 10);
   endtask

   task automatic writeByte(input logic [7:0] data, output logic ack);
      for (int i = 7; i >= 0; i--) writeBit(data[i]);
      readBit(ack);
   endtask

   task automatic readByte(output logic [7:0] data, input logic masterAck);
      logic b;
      data = '0;
      for (int i = 0; i < 8; i++) begin
         readBit(b);
         data = {data[6:0], b};
      end
      writeBit(masterAck);
   endtask

   function automatic wrEvent_t mkWr(input logic [7:0] a, input logic [7:0] d);
      wrEvent_t e;
      e.addr = a;
      e.data = d;
      return e;
   endfunction

   // Scoreboard monitor: every register strobe must match the next expected event.
   always @(negedge clk) begin
      if (resetN) begin
         if (regWe) begin
            if (expWr.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedWrite: got addr %h data %h, expected no write", regAddr, regWdata);
            end else begin
               monWr = expWr.pop_front();
               checkOutput("writeAddr", regAddr, monWr.addr);
               checkOutput("writeData", regWdata, monWr.data);
               regFile[regAddr] = regWdata;
            end
         end
         if (regRe) begin
            if (expRe.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedRead: got addr %h, expected no read", regAddr);
            end else begin
               monRe = expRe.pop_front();
               checkOutput("readAddr", regAddr, monRe);
            end
         end
         if (sdaOe) sawOe = 1'b1;
         if (busy) sawBusy = 1'b1;
         if (sdaOe != oePrev && scl && sclPrev) holdViol++;
      end
      oePrev  = sdaOe;
      sclPrev = scl;
   end

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic       ack;
      logic [7:0] data;
      logic       b;
      bit         found;

      for (int i = 0; i < 256; i++) regFile[i] = 8'h00;
      resetN = 1'b0;
      scl    = 1'b1;
      sdaLow = 1'b0;
      waitClk(3);
      checkOutput("resetSdaOe", {7'b0, sdaOe}, 8'h00);
      checkOutput("resetRegAddr", regAddr, 8'h00);
      checkOutput("resetRegWdata", regWdata, 8'h00);
      checkOutput("resetRegWe", {7'b0, regWe}, 8'h00);
      checkOutput("resetRegRe", {7'b0, regRe}, 8'h00);
      checkOutput("resetBusy", {7'b0, busy}, 8'h00);
      resetN = 1'b1;
      waitClk(5);

      $display("[TB] two-byte write to 0x2E");
      expWr.push_back(mkWr(8'h2E, 8'hFE));
      expWr.push_back(mkWr(8'h2F, 8'h07));
      busStart();
      writeByte(8'h96, ack);
      checkOutput("wrAddrAck", {7'b0, ack}, 8'h00);
      checkOutput("busyAfterMatch", {7'b0, busy}, 8'h01);
      writeByte(8'h2E, ack);
      checkOutput("wrSubAck", {7'b0, ack}, 8'h00);
      writeByte(8'hFE, ack);
      checkOutput("wrData0Ack", {7'b0, ack}, 8'h00);
      writeByte(8'h07, ack);
      checkOutput("wrData1Ack", {7'b0, ack}, 8'h00);
      busStop();
      waitClk(5);
      checkOutput("busyAfterStop", {7'b0, busy}, 8'h00);
      checkOutput("sdaOeAfterStop", {7'b0, sdaOe}, 8'h00);

      $display("[TB] repeated-start read from 0x2E");
      regFile[8'h2E] = 8'hBE;
      regFile[8'h2F] = 8'hEF;
      expRe.push_back(8'h2E);
      expRe.push_back(8'h2F);
      busStart();
      writeByte(8'h96, ack);
      checkOutput("rdAddrWAck", {7'b0, ack}, 8'h00);
      writeByte(8'h2E, ack);
      checkOutput("rdSubAck", {7'b0, ack}, 8'h00);
      busRepStart();
      writeByte(8'h97, ack);
      checkOutput("rdAddrRAck", {7'b0, ack}, 8'h00);
      readByte(data, 1'b0);
      checkOutput("rdByte0", data, 8'hBE);
      readByte(data, 1'b1);
      checkOutput("rdByte1", data, 8'hEF);
      busStop();
      waitClk(5);
      checkOutput("busyAfterRead", {7'b0, busy}, 8'h00);

      $display("[TB] address mismatch");
      sawOe   = 1'b0;
      sawBusy = 1'b0;
      busStart();
      writeByte(8'h90, ack);
      checkOutput("mismatchAddrNack", {7'b0, ack}, 8'h01);
      writeByte(8'h55, ack);
      checkOutput("mismatchDataNack", {7'b0, ack}, 8'h01);
      busStop();
      waitClk(5);
      checkOutput("mismatchNoDrive", {7'b0, sawOe}, 8'h00);
      checkOutput("mismatchNoBusy", {7'b0, sawBusy}, 8'h00);

      $display("[TB] pointer wrap");
      expWr.push_back(mkWr(8'hFF, 8'h11));
      expWr.push_back(mkWr(8'h00, 8'h22));
      busStart();
      writeByte(8'h96, ack);
      writeByte(8'hFF, ack);
      checkOutput("wrapSubAck", {7'b0, ack}, 8'h00);
      writeByte(8'h11, ack);
      checkOutput("wrapData0Ack", {7'b0, ack}, 8'h00);
      writeByte(8'h22, ack);
      checkOutput("wrapData1Ack", {7'b0, ack}, 8'h00);
      busStop();
      waitClk(5);

      $display("[TB] STOP in the middle of a data byte");
      busStart();
      writeByte(8'h96, ack);
      writeByte(8'h40, ack);
      writeBit(1'b1);
      writeBit(1'b0);
      writeBit(1'b1);
      writeBit(1'b0);
      busStop();
      waitClk(5);
      checkOutput("abortSdaOe", {7'b0, sdaOe}, 8'h00);
      checkOutput("abortBusy", {7'b0, busy}, 8'h00);
      expWr.push_back(mkWr(8'h40, 8'hA5));
      busStart();
      writeByte(8'h96, ack);
      checkOutput("afterAbortAddrAck", {7'b0, ack}, 8'h00);
      writeByte(8'h40, ack);
      writeByte(8'hA5, ack);
      checkOutput("afterAbortDataAck", {7'b0, ack}, 8'h00);
      busStop();
      waitClk(5);

      $display("[TB] reset while driving read data");
      expRe.push_back(8'h2E);
      busStart();
      writeByte(8'h96, ack);
      writeByte(8'h2E, ack);
      busRepStart();
      writeByte(8'h97, ack);
      readBit(b);
      checkOutput("resetRdBit7", {7'b0, b}, 8'h01);
      applyStimulus(1'b0, 1'b0, 1);
      found = 1'b0;
      for (int i = 0; i < 19 && !found; i++) begin
         if (sdaOe) found = 1'b1;
         else waitClk(1);
      end
      checkOutput("resetRdDriving", {7'b0, found}, 8'h01);
      resetN = 1'b0;
      #1;
      checkOutput("midResetSdaOe", {7'b0, sdaOe}, 8'h00);
      checkOutput("midResetRegAddr", regAddr, 8'h00);
      checkOutput("midResetBusy", {7'b0, busy}, 8'h00);
      checkOutput("midResetRegRe", {7'b0, regRe}, 8'h00);
      checkOutput("midResetRegWe", {7'b0, regWe}, 8'h00);
      checkOutput("midResetRegWdata", regWdata, 8'h00);
      applyStimulus(1'b0, 1'b0, 5);
      applyStimulus(1'b1, 1'b0, 5);
      resetN = 1'b1;
      waitClk(10);
      checkOutput("postResetSdaOe", {7'b0, sdaOe}, 8'h00);

      checkOutput("holdViolations", holdViol[7:0], 8'h00);
      checkOutput("pendingWrites", expWr.size() > 0 ? 8'h01 : 8'h00, 8'h00);
      checkOutput("pendingReads", expRe.size() > 0 ? 8'h01 : 8'h00, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
